pong_game_engine: RTL and testbench

- Game-logic stage in the game clock domain (i_clk_a), directly upstream of the clock-domain handshake into the pixel domain.
- Integrates paddle inputs, advances the ball once per game tick and resolves wall, paddle and miss events.
- Keeps score and runs the match phase machine.
- Presents one packed, registered game-state word; this word is the handshake's source data, with DATA_WIDTH = 50.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_game_engine_tick_gen.sv | 26 ++
 rtl/pong_game_engine.sv | 202 ++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared widths, phase encoding and the packed game-state word for the pong
// game-logic stage.
package pong_pkg;
    localparam int COORD_W = 10;
    localparam int SCORE_W = 4;
    localparam int STATE_W = 50;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SERVE = 2'd1,
        PH_PLAY  = 2'd2,
        PH_OVER  = 2'd3
    } phase_t;

    // Field order matches the wire format of o_state, MSB first.
    typedef struct packed {
        phase_t             phase;
        logic [SCORE_W-1:0] score_r;
        logic [SCORE_W-1:0] score_l;
        logic [COORD_W-1:0] pad_r_y;
        logic [COORD_W-1:0] pad_l_y;
        logic [COORD_W-1:0] ball_y;
        logic [COORD_W-1:0] ball_x;
    } game_state_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                     input logic [SCORE_W-1:0] s_max);
        return (s >= s_max) ? s_max : s + 1'b1;
    endfunction
endpackage

// File: rtl/pong_game_engine_tick_gen.sv
// Free-running game-tick divider: one-cycle pulse every TICK_DIV clocks,
// running in every phase.
module pong_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic i_clk_a,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge i_clk_a or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pong_game_engine.sv
// Pong game logic: paddles, ball, scoring and match phase, advanced once per
// game tick; o_state is the registered source word for the pixel-domain handshake.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int TICK_DIV     = 833333,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_TICKS  = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic               i_clk_a,
    input  logic               rst,
    input  logic               i_l_up,
    input  logic               i_l_dn,
    input  logic               i_r_up,
    input  logic               i_r_dn,
    input  logic               i_start,
    output logic [STATE_W-1:0] o_state,
    output logic               o_tick
);
    localparam int SRV_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [SRV_W-1:0] SERVE_LAST = SRV_W'(SERVE_TICKS - 1);

    localparam logic [COORD_W-1:0] BALL_X0  = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] BALL_Y0  = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] PAD_Y0   = COORD_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [COORD_W-1:0] BOUNCE_L = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0] BOUNCE_R = COORD_W'(PADDLE_XR - BALL_SIZE);
    localparam logic [COORD_W-1:0] WALL_BOT = COORD_W'(SCREEN_H - BALL_SIZE);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    // One extra bit of signed headroom so steps past an edge never wrap.
    typedef logic signed [COORD_W:0] scoord_t;
    localparam scoord_t ZERO     = '0;
    localparam scoord_t PAD_SPD  = scoord_t'(PADDLE_SPEED);
    localparam scoord_t PAD_MAX  = scoord_t'(SCREEN_H - PADDLE_H);
    localparam scoord_t PAD_H_S  = scoord_t'(PADDLE_H);
    localparam scoord_t BALL_SPD = scoord_t'(BALL_SPEED);
    localparam scoord_t BALL_SZ  = scoord_t'(BALL_SIZE);
    localparam scoord_t X_MAX    = scoord_t'(SCREEN_W - BALL_SIZE);
    localparam scoord_t Y_MAX    = scoord_t'(SCREEN_H - BALL_SIZE);
    localparam scoord_t XL_S     = scoord_t'(PADDLE_XL);
    localparam scoord_t XL_FACE  = scoord_t'(PADDLE_XL + PADDLE_W);
    localparam scoord_t XR_S     = scoord_t'(PADDLE_XR);
    localparam scoord_t XR_END   = scoord_t'(PADDLE_XR + PADDLE_W);

    function automatic logic [COORD_W-1:0] paddle_step(input logic [COORD_W-1:0] y,
                                                       input logic up, input logic dn);
        scoord_t t;
        t = $signed({1'b0, y});
        if (up && !dn) begin
            t = t - PAD_SPD;
            if (t < ZERO) t = ZERO;
        end else if (dn && !up) begin
            t = t + PAD_SPD;
            if (t > PAD_MAX) t = PAD_MAX;
        end
        return t[COORD_W-1:0];
    endfunction

    function automatic game_state_t home_state(input phase_t ph);
        game_state_t s;
        s.phase   = ph;
        s.score_r = '0;
        s.score_l = '0;
        s.pad_r_y = PAD_Y0;
        s.pad_l_y = PAD_Y0;
        s.ball_y  = BALL_Y0;
        s.ball_x  = BALL_X0;
        return s;
    endfunction

    game_state_t        st_q, st_d;
    logic               vx_q, vx_d;  // 1 = moving right
    logic               vy_q, vy_d;  // 1 = moving down
    logic [SRV_W-1:0]   serve_q, serve_d;
    logic               tick;
    scoord_t            bx, by, nx, ny, pl, pr;
    logic               l_hit, r_hit, l_miss, r_miss;
    logic [COORD_W-1:0] pl_next, pr_next;
    logic [SCORE_W-1:0] sr_inc, sl_inc;

    pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk_a(i_clk_a),
        .rst    (rst),
        .tick   (tick)
    );

    assign bx = $signed({1'b0, st_q.ball_x});
    assign by = $signed({1'b0, st_q.ball_y});
    assign pl = $signed({1'b0, st_q.pad_l_y});
    assign pr = $signed({1'b0, st_q.pad_r_y});
    assign nx = vx_q ? bx + BALL_SPD : bx - BALL_SPD;
    assign ny = vy_q ? by + BALL_SPD : by - BALL_SPD;

    // Collisions use the paddle positions from before this tick's move.
    assign l_hit  = !vx_q && (nx <= XL_FACE) && (nx + BALL_SZ > XL_S)
                    && (by + BALL_SZ > pl) && (by < pl + PAD_H_S);
    assign r_hit  = vx_q && (nx + BALL_SZ >= XR_S) && (nx < XR_END)
                    && (by + BALL_SZ > pr) && (by < pr + PAD_H_S);
    assign l_miss = (nx <= ZERO) && !l_hit;
    assign r_miss = (nx >= X_MAX) && !r_hit;

    assign pl_next = paddle_step(st_q.pad_l_y, i_l_up, i_l_dn);
    assign pr_next = paddle_step(st_q.pad_r_y, i_r_up, i_r_dn);
    assign sr_inc  = score_inc(st_q.score_r, SCORE_TOP);
    assign sl_inc  = score_inc(st_q.score_l, SCORE_TOP);

    always_comb begin
        st_d    = st_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        serve_d = serve_q;
        case (st_q.phase)
            PH_IDLE: begin
                if (i_start) begin
                    st_d.phase = PH_SERVE;
                    serve_d    = '0;
                end
            end
            PH_SERVE: begin
                st_d.pad_l_y = pl_next;
                st_d.pad_r_y = pr_next;
                if (serve_q == SERVE_LAST) st_d.phase = PH_PLAY;
                else serve_d = serve_q + 1'b1;
            end
            PH_PLAY: begin
                st_d.pad_l_y = pl_next;
                st_d.pad_r_y = pr_next;
                if (!(l_miss || r_miss)) begin
                    if (ny <= ZERO) begin
                        st_d.ball_y = '0;
                        vy_d        = 1'b1;
                    end else if (ny >= Y_MAX) begin
                        st_d.ball_y = WALL_BOT;
                        vy_d        = 1'b0;
                    end else begin
                        st_d.ball_y = ny[COORD_W-1:0];
                    end
                end
                if (l_hit) begin
                    st_d.ball_x = BOUNCE_L;
                    vx_d        = 1'b1;
                end else if (r_hit) begin
                    st_d.ball_x = BOUNCE_R;
                    vx_d        = 1'b0;
                end else if (l_miss) begin
                    st_d.score_r = sr_inc;
                    st_d.ball_x  = BALL_X0;
                    st_d.ball_y  = BALL_Y0;
                    st_d.phase   = (sr_inc == SCORE_TOP) ? PH_OVER : PH_SERVE;
                    vx_d         = 1'b0;
                    serve_d      = '0;
                end else if (r_miss) begin
                    st_d.score_l = sl_inc;
                    st_d.ball_x  = BALL_X0;
                    st_d.ball_y  = BALL_Y0;
                    st_d.phase   = (sl_inc == SCORE_TOP) ? PH_OVER : PH_SERVE;
                    vx_d         = 1'b1;
                    serve_d      = '0;
                end else begin
                    st_d.ball_x = nx[COORD_W-1:0];
                end
            end
            PH_OVER: begin
                if (i_start) begin
                    st_d    = home_state(PH_SERVE);
                    serve_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_a or negedge rst) begin
        if (!rst) begin
            st_q    <= home_state(PH_IDLE);
            vx_q    <= 1'b1;
            vy_q    <= 1'b1;
            serve_q <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_tick <= tick;
            if (tick) begin
                st_q    <= st_d;
                vx_q    <= vx_d;
                vy_q    <= vy_d;
                serve_q <= serve_d;
            end
        end
    end

    assign o_state = st_q;
endmodule

// File: tb/tb_pong_game_engine.sv
// Self-checking bench for pong_game_engine: each game tick is compared against
// a reference game model kept as plain integers.
module tb_pong_game_engine;
    localparam int TICK_DIV    = 4;
    localparam int SERVE_TICKS = 2;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int BALL        = 8;
    localparam int PAD_W       = 8;
    localparam int PAD_H       = 64;
    localparam int XL          = 16;
    localparam int XR          = 616;
    localparam int PAD_SPD     = 4;
    localparam int BALL_SPD    = 2;
    localparam int SCORE_MAX   = 9;
    localparam logic [49:0] HOME_WORD  = {2'd0, 4'd0, 4'd0, 10'd208, 10'd208, 10'd236, 10'd316};
    localparam logic [49:0] SERVE_WORD = {2'd1, 4'd0, 4'd0, 10'd208, 10'd208, 10'd236, 10'd316};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0, start = 1'b0;
    logic [49:0] state;
    logic        tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: positions in pixels, velocities as +1/-1.
    int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_ph, m_serve;
    int n_lhit = 0, n_rhit = 0;

    always #5 clk = ~clk;

    pong_game_engine #(
        .TICK_DIV   (TICK_DIV),
        .SERVE_TICKS(SERVE_TICKS)
    ) dut (
        .i_clk_a(clk),
        .rst    (rst_n),
        .i_l_up (l_up),
        .i_l_dn (l_dn),
        .i_r_up (r_up),
        .i_r_dn (r_dn),
        .i_start(start),
        .o_state(state),
        .o_tick (tick)
    );

    function automatic int move_pad(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - PAD_SPD < 0) ? 0 : y - PAD_SPD;
        if (dn && !up) return (y + PAD_SPD > SCREEN_H - PAD_H) ? SCREEN_H - PAD_H : y + PAD_SPD;
        return y;
    endfunction

    function automatic void model_home(input int ph);
        m_ph = ph; m_sl = 0; m_sr = 0; m_serve = 0;
        m_bx = (SCREEN_W - BALL) / 2;
        m_by = (SCREEN_H - BALL) / 2;
        m_pl = (SCREEN_H - PAD_H) / 2;
        m_pr = (SCREEN_H - PAD_H) / 2;
    endfunction

    function automatic void model_reset();
        model_home(0);
        m_dx = 1;
        m_dy = 1;
    endfunction

    function automatic logic [49:0] model_word();
        return {2'(m_ph), 4'(m_sr), 4'(m_sl), 10'(m_pr), 10'(m_pl), 10'(m_by), 10'(m_bx)};
    endfunction

    function automatic void model_step(input bit lu, input bit ld, input bit ru,
                                       input bit rd, input bit st);
        int opl, opr, nx, ny, ndy;
        bit lh, rh;
        opl = m_pl;
        opr = m_pr;
        case (m_ph)
            0: if (st) begin m_ph = 1; m_serve = 0; end
            1: begin
                m_pl = move_pad(m_pl, lu, ld);
                m_pr = move_pad(m_pr, ru, rd);
                if (m_serve + 1 >= SERVE_TICKS) m_ph = 2;
                else m_serve++;
            end
            2: begin
                m_pl = move_pad(m_pl, lu, ld);
                m_pr = move_pad(m_pr, ru, rd);
                nx  = m_bx + BALL_SPD * m_dx;
                ny  = m_by + BALL_SPD * m_dy;
                ndy = m_dy;
                if (ny <= 0) begin ny = 0; ndy = 1; end
                else if (ny >= SCREEN_H - BALL) begin ny = SCREEN_H - BALL; ndy = -1; end
                lh = (m_dx < 0) && (nx <= XL + PAD_W) && (nx + BALL > XL)
                     && (m_by + BALL > opl) && (m_by < opl + PAD_H);
                rh = (m_dx > 0) && (nx + BALL >= XR) && (nx < XR + PAD_W)
                     && (m_by + BALL > opr) && (m_by < opr + PAD_H);
                if (lh || rh) begin
                    m_bx = lh ? XL + PAD_W : XR - BALL;
                    m_dx = -m_dx;
                    m_by = ny;
                    m_dy = ndy;
                    if (lh) n_lhit++; else n_rhit++;
                end else if (nx <= 0 || nx >= SCREEN_W - BALL) begin
                    if (nx <= 0) begin
                        m_sr = (m_sr < SCORE_MAX) ? m_sr + 1 : SCORE_MAX;
                        m_dx = -1;
                    end else begin
                        m_sl = (m_sl < SCORE_MAX) ? m_sl + 1 : SCORE_MAX;
                        m_dx = 1;
                    end
                    m_bx = (SCREEN_W - BALL) / 2;
                    m_by = (SCREEN_H - BALL) / 2;
                    m_ph = (m_sr == SCORE_MAX || m_sl == SCORE_MAX) ? 3 : 1;
                    m_serve = 0;
                end else begin
                    m_bx = nx;
                    m_by = ny;
                    m_dy = ndy;
                end
            end
            default: if (st) model_home(1);
        endcase
    endfunction

    // Button pair {up, dn} steering a paddle's centre toward the ball's centre.
    function automatic logic [1:0] track(input int pad, input int ball_y);
        if (pad + PAD_H / 2 < ball_y + BALL / 2 - 2) return 2'b01;
        if (pad + PAD_H / 2 > ball_y + BALL / 2 + 2) return 2'b10;
        return 2'b00;
    endfunction

    // Drive one tick's inputs, wait for o_tick, then advance the model.
    task automatic run_tick(input bit lu, input bit ld, input bit ru, input bit rd,
                            input bit st, output logic [49:0] got, output bit timed_out);
        l_up = lu; l_dn = ld; r_up = ru; r_dn = rd; start = st;
        timed_out = 1'b1;
        for (int n = 0; n < 4 * TICK_DIV; n++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        got = state;
        model_step(lu, ld, ru, rd, st);
    endtask

    task automatic test_reset();
        logic exp_t;
        rst_n = 1'b0;
        l_up = 0; l_dn = 0; r_up = 0; r_dn = 0; start = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== HOME_WORD || tick !== 1'b0)
            $display("FAIL reset_state: got %h tick %b expected %h tick 0", state, tick, HOME_WORD);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 3 * TICK_DIV; k++) begin
            @(negedge clk);
            exp_t = ((k % TICK_DIV) == 0);
            n_checks++;
            if (tick !== exp_t)
                $display("FAIL tick_period cycle %0d: got %b expected %b", k, tick, exp_t);
            else n_pass++;
        end
        n_checks++;
        if (state !== HOME_WORD)
            $display("FAIL idle_hold: got %h expected %h", state, HOME_WORD);
        else n_pass++;
    endtask

    task automatic test_serve();
        logic [49:0] got;
        bit to;
        int exp_ph[5] = '{1, 1, 2, 2, 2};
        int exp_x[5]  = '{316, 316, 316, 318, 320};
        int exp_y[5]  = '{236, 236, 236, 238, 240};
        for (int k = 0; k < 5; k++) begin
            run_tick(0, 0, 0, 0, k == 0, got, to);
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL serve_model tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
            n_checks++;
            if (got[49:48] !== 2'(exp_ph[k]) || got[19:10] !== 10'(exp_y[k]) || got[9:0] !== 10'(exp_x[k]))
                $display("FAIL serve_seq tick %0d: got phase %0d ball (%0d,%0d) expected phase %0d ball (%0d,%0d)",
                         k, got[49:48], got[9:0], got[19:10], exp_ph[k], exp_x[k], exp_y[k]);
            else n_pass++;
        end
    endtask

    task automatic test_paddles();
        logic [49:0] got;
        bit to;
        int e;
        for (int k = 1; k <= 60; k++) begin
            run_tick(1, 0, 0, 0, 0, got, to);
            e = 208 - PAD_SPD * k;
            if (e < 0) e = 0;
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL paddle_model tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
            if (k >= 50) begin
                n_checks++;
                if (got[29:20] !== 10'(e))
                    $display("FAIL paddle_top tick %0d: got %0d expected %0d", k, got[29:20], e);
                else n_pass++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            run_tick(1, 1, 1, 1, 0, got, to);
            n_checks++;
            if (to || got !== model_word() || got[39:20] !== {10'd208, 10'd0})
                $display("FAIL paddle_both tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
        end
    endtask

    task automatic test_rally();
        logic [49:0] got;
        bit to;
        logic [1:0] lb, rb;
        int lh0 = n_lhit, rh0 = n_rhit;
        for (int k = 0; k < 700; k++) begin
            lb = track(m_pl, m_by);
            rb = track(m_pr, m_by);
            if ($urandom_range(0, 7) == 0) lb = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rb = 2'($urandom_range(0, 3));
            run_tick(lb[1], lb[0], rb[1], rb[0], 0, got, to);
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL rally tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
        end
        n_checks++;
        if (n_lhit == lh0 || n_rhit == rh0)
            $display("FAIL rally_hits: got left %0d right %0d expected both > 0", n_lhit - lh0, n_rhit - rh0);
        else n_pass++;
    endtask

    task automatic test_over_and_restart();
        logic [49:0] got, saved;
        bit to;
        logic [1:0] lb;
        bit rup;
        for (int k = 0; k < 4000 && m_ph != 3; k++) begin
            lb  = track(m_pl, m_by);
            rup = (m_by + BALL / 2 >= SCREEN_H / 2);
            run_tick(lb[1], lb[0], rup, !rup, 0, got, to);
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL to_over tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
        end
        n_checks++;
        if (got[49:48] !== 2'd3 || got[43:40] !== 4'(SCORE_MAX) || got[19:0] !== {10'd236, 10'd316})
            $display("FAIL over_reached: got %h expected phase 3 score_l %0d ball centred", got, SCORE_MAX);
        else n_pass++;
        saved = got;
        for (int k = 0; k < 6; k++) begin
            run_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, got, to);
            n_checks++;
            if (to || got !== saved || got !== model_word())
                $display("FAIL over_frozen tick %0d: got %h expected %h", k, got, saved);
            else n_pass++;
        end
        run_tick(0, 0, 0, 0, 1, got, to);
        n_checks++;
        if (to || got !== SERVE_WORD || got !== model_word())
            $display("FAIL restart: got %h expected %h", got, SERVE_WORD);
        else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        logic [49:0] got;
        bit to;
        logic [1:0] lb, rb;
        for (int k = 0; k < 12; k++) begin
            lb = track(m_pl, m_by);
            rb = track(m_pr, m_by);
            run_tick(lb[1], lb[0], rb[1], rb[0], 1, got, to);
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL pre_reset tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== HOME_WORD || tick !== 1'b0)
            $display("FAIL mid_reset: got %h tick %b expected %h tick 0", state, tick, HOME_WORD);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_tick(0, 1, 1, 0, 0, got, to);
        n_checks++;
        if (to || got !== model_word())
            $display("FAIL post_reset_idle: got %h expected %h", got, model_word());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [49:0] got;
        bit to;
        for (int k = 0; k < 500; k++) begin
            run_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15) == 0, got, to);
            n_checks++;
            if (to || got !== model_word())
                $display("FAIL random tick %0d: got %h expected %h", k, got, model_word());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddles();
        test_rally();
        test_over_and_restart();
        test_reset_mid_play();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
